// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin stream arbiter.
// The FSM states stay plain constants so older tools can read them.
package rr_mux4_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef logic [1:0] idx_t;
    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t OWN  = 1'b1;

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Bundle of the requester-side and output-side stream signals of the arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface rr_mux4_arbiter_if
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic                     out_ready;
    idx_t                     sel;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, sel, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, sel, busy
    );

endinterface

// File: rtl/rr_mux4_arbiter_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, modulo four.
// The request vector is rotated, fixed-priority scanned, and the offset is added back.
module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               ptr,
    output logic               found,
    output idx_t               idx
);

    logic [NUM_REQ-1:0] rot;
    idx_t               off;

    always_comb begin
        rot = req;
        unique case (ptr)
            2'd0: rot = req;
            2'd1: rot = {req[0],   req[3:1]};
            2'd2: rot = {req[1:0], req[3:2]};
            2'd3: rot = {req[2:0], req[3]};
        endcase
    end

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = idx_t'(i);
            end
        end
    end

    assign found = |rot;
    assign idx   = off + ptr;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter steering one of four valid/ready streams onto a single output.
// A grant lasts until the owner's last beat or MAX_BURST accepted beats, then priority rotates.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk,
    input logic               reset,
    rr_mux4_arbiter_if.slave  bus
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t           state_q, state_d;
    idx_t             sel_q, sel_d;
    idx_t             ptr_q, ptr_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;

    logic             found;
    idx_t             win;
    logic             own;
    logic             xfer;
    logic             done;
    logic [NUM_REQ-1:0] ready;
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    rr_pick4 u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Output steering is purely a function of the registered owner.
    always_comb begin
        ready = '0;
        if (own) begin
            ready[sel_q] = bus.out_ready;
        end
    end

    assign own           = (state_q == OWN);
    assign bus.out_valid = own & bus.req_valid[sel_q];
    assign bus.out_data  = own ? data_arr[sel_q] : '0;
    assign bus.out_last  = own & bus.req_last[sel_q];
    assign bus.req_ready = ready;
    assign bus.sel       = sel_q;
    assign bus.busy      = own;

    assign xfer = bus.out_valid & bus.out_ready;
    assign done = xfer & (bus.out_last | (beat_cnt_q == BURST_LAST));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d      = win;
                    beat_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (done) begin
                    state_d    = IDLE;
                    ptr_d      = sel_q + 2'd1;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench: per-requester beat sources and an expected-output scoreboard,
// with one task per scenario doing its own targeted checks.
module tb_rr_mux4_arbiter;
    import rr_mux4_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rr_mux4_arbiter_if #(.WIDTH(8)) bus ();

    rr_mux4_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [8:0]  src_mem [4][32];
    int          head [4];
    int          tail [4];
    logic [3:0]  hold = '0;
    logic [3:0]  hs = '0;
    logic [10:0] exp_q [$];
    int          xfer_cyc [$];
    logic [10:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Sources: present the head beat at negedge, advance on the handshake seen last cycle.
    // Monitor: 1 time unit later, any transfer due at the next posedge is scored.
    initial begin
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) head[i] = head[i] + 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (head[i] != tail[i] && !hold[i]) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[i*8 +: 8] = src_mem[i][head[i] % 32][7:0];
                    bus.req_last[i]        = src_mem[i][head[i] % 32][8];
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[i*8 +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
            #1;
            if (reset) begin
                hs = '0;
            end else begin
                hs = bus.req_valid & bus.req_ready;
                if (bus.out_valid && bus.out_ready) begin
                    xfer_cyc.push_back(cyc);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL beat_unexpected: got sel=%0d last=%0b data=%02h, required none",
                                 bus.sel, bus.out_last, bus.out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({bus.sel, bus.out_last, bus.out_data} !== mon_e) begin
                            n_bad++;
                            $display("FAIL beat: got sel=%0d last=%0b data=%02h, required sel=%0d last=%0b data=%02h",
                                     bus.sel, bus.out_last, bus.out_data,
                                     mon_e[10:9], mon_e[8], mon_e[7:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL sim_timeout: got no end of test, required end of test");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    function automatic void src_push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][tail[r] % 32] = {l, d};
        tail[r] = tail[r] + 1;
    endfunction

    function automatic void exp_push(input idx_t s, input logic l, input logic [7:0] d);
        exp_q.push_back({s, l, d});
    endfunction

    task automatic clear_sources();
        hs = '0;
        hold = '0;
        for (int i = 0; i < 4; i++) head[i] = tail[i];
        exp_q.delete();
        xfer_cyc.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        clear_sources();
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        ok = (exp_q.size() == 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) src_push(i, 8'hE0 + 8'(i), 1'b1);
        repeat (3) step();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 0000", bus.req_ready); end
        n_cmp++; if (bus.sel !== 2'd0) begin n_bad++; $display("FAIL rst_sel: got %0d, required 0", bus.sel); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %02h, required 00", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        clear_sources();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        src_push(0, 8'hA1, 1'b0);
        src_push(0, 8'hA2, 1'b0);
        src_push(0, 8'hA3, 1'b1);
        exp_push(2'd0, 1'b0, 8'hA1);
        exp_push(2'd0, 1'b0, 8'hA2);
        exp_push(2'd0, 1'b1, 8'hA3);
        mid();
        n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_arb_cycle: got busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
        end
        step();
        n_cmp++; if (bus.busy !== 1'b1 || bus.sel !== 2'd0) begin
            n_bad++; $display("FAIL single_grant: got busy=%b sel=%0d, required 1 0", bus.busy, bus.sel);
        end
        mid();
        n_cmp++; if (bus.req_ready !== 4'b0001 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1) begin
            n_bad++; $display("FAIL single_first_beat: got ready=%b valid=%b data=%02h, required 0001 1 a1",
                              bus.req_ready, bus.out_valid, bus.out_data);
        end
        drain(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_drain: got %0d beats left, required 0", exp_q.size()); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got busy=%b, required 0", bus.busy); end
        // Pointer now at 1: requester 1 must beat requester 0.
        src_push(0, 8'h10, 1'b1);
        src_push(1, 8'h11, 1'b1);
        exp_push(2'd1, 1'b1, 8'h11);
        exp_push(2'd0, 1'b1, 8'h10);
        drain(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ptr_after_release: got %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        src_push(0, 8'h20, 1'b1);
        src_push(0, 8'h24, 1'b1);
        src_push(1, 8'h21, 1'b1);
        src_push(2, 8'h22, 1'b1);
        src_push(3, 8'h23, 1'b1);
        exp_push(2'd0, 1'b1, 8'h20);
        exp_push(2'd1, 1'b1, 8'h21);
        exp_push(2'd2, 1'b1, 8'h22);
        exp_push(2'd3, 1'b1, 8'h23);
        exp_push(2'd0, 1'b1, 8'h24);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            mid();
            n_cmp++; if (!$onehot0(bus.req_ready)) begin
                n_bad++; $display("FAIL rr_ready_onehot: got %b, required at most one bit", bus.req_ready);
            end
            n++;
        end
        repeat (3) step();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_drain: got %0d beats left, required 0", exp_q.size()); end
        n_cmp++; if (xfer_cyc.size() != 5) begin
            n_bad++; $display("FAIL rr_xfer_count: got %0d, required 5", xfer_cyc.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_cmp++; if (xfer_cyc[i] - xfer_cyc[i-1] != 2) begin
                    n_bad++; $display("FAIL rr_bubble: got gap %0d, required 2", xfer_cyc[i] - xfer_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        bit ok;
        apply_reset();
        for (int i = 1; i <= 6; i++) src_push(1, 8'h30 + 8'(i), (i == 6));
        src_push(3, 8'h3A, 1'b1);
        for (int i = 1; i <= 4; i++) exp_push(2'd1, 1'b0, 8'h30 + 8'(i));
        exp_push(2'd3, 1'b1, 8'h3A);
        exp_push(2'd1, 1'b0, 8'h35);
        exp_push(2'd1, 1'b1, 8'h36);
        drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_cap_drain: got %0d beats left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        src_push(2, 8'h41, 1'b0);
        src_push(2, 8'h42, 1'b1);
        exp_push(2'd2, 1'b0, 8'h41);
        exp_push(2'd2, 1'b1, 8'h42);
        step();
        n_cmp++; if (bus.busy !== 1'b1 || bus.sel !== 2'd2) begin
            n_bad++; $display("FAIL bp_grant: got busy=%b sel=%0d, required 1 2", bus.busy, bus.sel);
        end
        step();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mid();
            n_cmp++; if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h42) begin
                n_bad++; $display("FAIL bp_stall: got ready=%b valid=%b data=%02h, required 0000 1 42",
                                  bus.req_ready, bus.out_valid, bus.out_data);
            end
            if (k == 0) step();
        end
        step();
        bus.out_ready = 1'b1;
        mid();
        n_cmp++; if (bus.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL bp_resume_ready: got %b, required 0100", bus.req_ready);
        end
        drain(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_drain: got %0d beats left, required 0", exp_q.size()); end
        n_cmp++; if (xfer_cyc.size() != 2) begin
            n_bad++; $display("FAIL bp_xfer_count: got %0d, required 2", xfer_cyc.size());
        end
    endtask

    task automatic test_owner_drop();
        bit ok;
        apply_reset();
        src_push(0, 8'h51, 1'b0);
        src_push(0, 8'h52, 1'b0);
        src_push(0, 8'h53, 1'b1);
        src_push(2, 8'h5A, 1'b1);
        exp_push(2'd0, 1'b0, 8'h51);
        exp_push(2'd0, 1'b0, 8'h52);
        exp_push(2'd0, 1'b1, 8'h53);
        exp_push(2'd2, 1'b1, 8'h5A);
        step();
        step();
        hold[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.sel !== 2'd0 || bus.busy !== 1'b1) begin
                n_bad++; $display("FAIL drop_hold: got valid=%b sel=%0d busy=%b, required 0 0 1",
                                  bus.out_valid, bus.sel, bus.busy);
            end
        end
        hold[0] = 1'b0;
        drain(30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_drain: got %0d beats left, required 0", exp_q.size()); end
    endtask

    // Entered with ptr=3 from the previous scenario, so a surviving pointer would show.
    task automatic test_reset_mid_burst();
        bit ok;
        src_push(1, 8'h61, 1'b0);
        src_push(1, 8'h62, 1'b0);
        src_push(1, 8'h63, 1'b1);
        exp_push(2'd1, 1'b0, 8'h61);
        step();
        n_cmp++; if (bus.busy !== 1'b1 || bus.sel !== 2'd1) begin
            n_bad++; $display("FAIL rmb_grant: got busy=%b sel=%0d, required 1 1", bus.busy, bus.sel);
        end
        step();
        reset = 1'b1;
        step();
        n_cmp++; if (bus.busy !== 1'b0 || bus.sel !== 2'd0 || bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL rmb_state: got busy=%b sel=%0d valid=%b ready=%b, required 0 0 0 0000",
                              bus.busy, bus.sel, bus.out_valid, bus.req_ready);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rmb_first_beat: got %0d beats left, required 0", exp_q.size()); end
        clear_sources();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_push(i, 8'h70 + 8'(i), 1'b1);
            exp_push(idx_t'(i), 1'b1, 8'h70 + 8'(i));
        end
        drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmb_drain: got %0d beats left, required 0", exp_q.size()); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_owner_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares one 4:1 select datapath among four valid/ready requesters. It picks one requester and holds the grant for a burst. It steers that requester's data, last flag and handshake onto a single output stream, then rotates priority. It sits upstream of any single-consumer resource that four sources must share, and also exports the registered select.

Parameters:
WIDTH, 8, data width per requester.
MAX_BURST, 4, maximum accepted beats per grant before forced rotation (legal range 1..255).

Ports:
clk  input  1  clock.
reset  input  1  synchronous active-high reset.
req_valid  input  4  per-requester valid; bit i = requester i.
req_data  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
req_last  input  4  per-requester end-of-packet flag.
req_ready  output  4  per-requester ready; at most one bit high.
out_valid  output  1  output stream valid.
out_data  output  WIDTH  output stream data.
out_last  output  1  output stream last flag.
out_ready  input  1  downstream ready.
sel  output  2  registered index of the current owner (drives the mux select).
busy  output  1  high while in OWN.

Behaviour:
- One clock (clk); reset is synchronous, active-high (reset), sampled on the rising clk edge.
- Reset values:
  - state=IDLE, sel=0, ptr=0, beat_cnt=0.
  - out_valid=0, req_ready=0, busy=0.
  - out_data and out_last are don't-care while out_valid=0; the implementation drives them to 0.
- Reset mid-burst abandons the burst immediately. No partial state survives.
- State IDLE:
  - out_valid=0, req_ready=0.
  - If any req_valid bit is high, choose the first high bit searching ptr, ptr+1, ... (mod 4).
  - Register the winner into sel, clear beat_cnt, and go to OWN.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after the request is seen.
- State OWN, combinational from registered sel:
  - out_valid=req_valid[sel], out_data=req_data[sel], out_last=req_last[sel].
  - req_ready[sel]=out_ready; the other three req_ready bits are 0.
- Transfer = out_valid & out_ready. On a transfer, beat_cnt increments.
- Release from OWN to IDLE, with ptr=sel+1 (mod 4, wraps 3->0), happens on a transfer where either:
  - out_last=1, or
  - beat_cnt+1 == MAX_BURST.
- A forced release at MAX_BURST does not alter out_last. Packets longer than MAX_BURST are split across grants, and the requester re-arbitrates for the remainder.
- Owner deasserts req_valid mid-burst: the grant is held and out_valid=0. There is no timeout, and other requesters wait.
- A requester that raises req_valid while another owns the stream waits. It is never granted mid-burst.
- Minimum gap between grants is one IDLE cycle. Back-to-back bursts from different requesters therefore have a 1-cycle bubble.
- All four requesting continuously from reset: grant order 0,1,2,3,0,...
- Only requester 2 requesting with ptr=3: search 3,0,1,2 and grant 2.
- beat_cnt width is 8 bits; it never exceeds MAX_BURST-1 while in OWN.
- Fairness: any requester holding req_valid is granted within 3 other grants.

Decomposition:
- Shared package: state enum (IDLE=1'b0, OWN=1'b1), constant NUM_REQ=4, and the index type as 2-bit logic.
- One sub-module, rr_pick4:
  - Purely combinational.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: found and idx[1:0].
  - Implemented by rotating req by ptr, doing a fixed-priority find, and adding ptr back mod 4.
- The top level holds the FSM, ptr, sel, beat_cnt and the output steering.

Test Plan:
- Reset then single requester: req_valid=4'b0001, 3 beats of data 0xA1,0xA2,0xA3 with last on the third and out_ready=1.
  - sel=0; first transfer in cycle 2 after valid.
  - out_data sequence A1,A2,A3; out_last on beat 3.
  - IDLE follows, and ptr=1.
- All four valid continuously, 1-beat packets (last=1), out_ready=1.
  - Grants 0,1,2,3,0 with sel sequence 0,1,2,3,0.
  - Exactly one req_ready bit high per grant, with a 1-cycle IDLE bubble between grants.
- Burst cap with MAX_BURST=4: requester 1 sends 6 beats, last on beat 6; requester 3 also valid.
  - Requester 1 releases after beat 4 without out_last.
  - Requester 3 is granted next.
  - Requester 1 then finishes beats 5-6.
- Backpressure: out_ready toggles 1,0,0,1 during a 2-beat burst.
  - req_ready[sel] mirrors out_ready and data holds while stalled.
  - Exactly 2 transfers occur, with no duplication or loss.
- Owner drops valid: requester 0 deasserts req_valid for 3 cycles mid-burst while requester 2 is valid.
  - out_valid=0 for those cycles and sel stays 0.
  - Requester 2 is granted only after requester 0's last beat.
- Reset mid-burst: reset asserted during beat 2 of requester 1.
  - Next cycle: state IDLE, sel=0, ptr=0, out_valid=0, req_ready=0.
  - With all valid afterwards, the first grant is requester 0.
